// File: rtl/pe_result_collector.sv
// Result collector behind the double-precision PE: buffers the unstallable PE
// stream in a FIFO, optionally keeps only the final partial sum per vector,
// and hands results downstream as an AXI-stream master with credit-based issue.
module pe_result_collector #(
  parameter int DWIDTH     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16,
  parameter int PE_LATENCY = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic              cfg_reduce,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              issue_fire,
  output logic              credit_ok,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic [DWIDTH-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              vec_done,
  output logic [1:0]        err
);

  localparam int CW = $clog2(FIFO_DEPTH);

  logic             reduce_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] elem_cnt;

  logic [DWIDTH:0]  mem [FIFO_DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    rd_ptr;
  logic [CW:0]      count;
  logic [CW:0]      inflight;

  logic             cur_reduce;
  logic [LEN_W-1:0] cur_len;
  logic [LEN_W-1:0] cur_cnt;
  logic [LEN_W-1:0] eff_len;
  logic             is_last;
  logic             push;
  logic             push_ok;
  logic             pop;
  logic             empty;
  logic             full;
  logic             inc;
  logic             dec;
  logic [DWIDTH:0]  head;

  // A cfg_start in the same cycle as in_valid makes that element index 0 under the new config.
  always_comb begin
    cur_reduce = cfg_start ? cfg_reduce : reduce_q;
    cur_len    = cfg_start ? cfg_len : len_q;
    cur_cnt    = cfg_start ? '0 : elem_cnt;
    eff_len    = (cur_len == '0) ? LEN_W'(1) : cur_len;
    is_last    = (cur_cnt == eff_len - LEN_W'(1));
    push       = in_valid && (!cur_reduce || is_last);
    empty      = (count == '0);
    full       = (count == (CW+1)'(FIFO_DEPTH));
    pop        = !empty && m_tready;
    push_ok    = push && (!full || pop);
    dec        = in_valid && (inflight != '0);
    inc        = issue_fire && (inflight != '1);
    head       = mem[rd_ptr];
  end

  assign m_tvalid  = !empty;
  assign m_tdata   = empty ? '0 : head[DWIDTH-1:0];
  assign m_tlast   = empty ? 1'b0 : head[DWIDTH];
  assign credit_ok = ({1'b0, count} + {1'b0, inflight}) < (CW+2)'(FIFO_DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reduce_q <= 1'b0;
      len_q    <= LEN_W'(1);
      elem_cnt <= '0;
    end else begin
      if (cfg_start) begin
        reduce_q <= cfg_reduce;
        len_q    <= cfg_len;
      end
      if (in_valid)
        elem_cnt <= is_last ? '0 : cur_cnt + LEN_W'(1);
      else
        elem_cnt <= cur_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {is_last, in_data};
  end

  // Full with a simultaneous pop still accepts the push; empty never bypasses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      vec_done <= 1'b0;
      err      <= 2'b00;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + CW'(1);
      if (pop)
        rd_ptr <= rd_ptr + CW'(1);
      if (push_ok && !pop)
        count <= count + (CW+1)'(1);
      else if (pop && !push_ok)
        count <= count - (CW+1)'(1);
      vec_done <= push_ok && is_last;
      if (push && !push_ok)
        err[0] <= 1'b1;
      if (in_valid && (inflight == '0))
        err[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      inflight <= '0;
    else if (inc && !dec)
      inflight <= inflight + (CW+1)'(1);
    else if (dec && !inc)
      inflight <= inflight - (CW+1)'(1);
  end

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench for pe_result_collector: pass/reduce streams, credit,
// overflow, underflow and mid-stream reset, with hand-computed expectations.
module tb_pe_result_collector;

  localparam int DWIDTH     = 64;
  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W      = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cfg_start = 1'b0;
  logic              cfg_reduce = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              issue_fire = 1'b0;
  logic              credit_ok;
  logic [DWIDTH-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic [DWIDTH-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready = 1'b0;
  logic              m_tlast;
  logic              vec_done;
  logic [1:0]        err;

  int          vectors = 0;
  int          miscompares = 0;
  int          vd_cnt = 0;
  logic [64:0] got_q[$];
  logic [64:0] exp_q[$];

  pe_result_collector #(
    .DWIDTH(DWIDTH), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W), .PE_LATENCY(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_reduce(cfg_reduce),
    .cfg_len(cfg_len), .issue_fire(issue_fire), .credit_ok(credit_ok),
    .in_data(in_data), .in_valid(in_valid), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .vec_done(vec_done), .err(err)
  );

  initial forever #5 clk = ~clk;

  // Record every accepted output beat and every vec_done pulse.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready)
      got_q.push_back({m_tlast, m_tdata});
    if (rst_n && vec_done)
      vd_cnt++;
  end

  function automatic logic [63:0] r2b(input real r);
    return $realtobits(r);
  endfunction

  task automatic checkOutput(input string tag, input logic [64:0] actual, input logic [64:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iv, input logic [63:0] d, input logic fire);
    in_valid   = iv;
    in_data    = d;
    issue_fire = fire;
    tick();
    in_valid   = 1'b0;
    in_data    = '0;
    issue_fire = 1'b0;
  endtask

  task automatic startVector(input logic red, input logic [LEN_W-1:0] len);
    cfg_start  = 1'b1;
    cfg_reduce = red;
    cfg_len    = len;
    tick();
    cfg_start  = 1'b0;
  endtask

  task automatic checkStream(input string name, input int base, input int vd_base, input int exp_vd);
    checkOutput({name, "_beats"}, 65'(got_q.size() - base), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        checkOutput($sformatf("%s_beat%0d", name, i), got_q[base + i], exp_q[i]);
    checkOutput({name, "_vec_done"}, 65'(vd_cnt - vd_base), 65'(exp_vd));
    exp_q.delete();
  endtask

  initial begin
    int base;
    int vd_base;
    real pass_vals[5];
    real red_vals[6];
    pass_vals = '{1.0, 2.0, 3.0, 4.0, 5.0};
    red_vals  = '{1.0, 3.0, 6.0, 2.0, 5.0, 9.0};

    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("rst_tvalid", 65'(m_tvalid), 65'(0));
    checkOutput("rst_tlast", 65'(m_tlast), 65'(0));
    checkOutput("rst_tdata", 65'(m_tdata), 65'(0));
    checkOutput("rst_vec_done", 65'(vec_done), 65'(0));
    checkOutput("rst_err", 65'(err), 65'(0));
    checkOutput("rst_credit", 65'(credit_ok), 65'(1));

    // Pass mode, len 4
    base = got_q.size();
    vd_base = vd_cnt;
    m_tready = 1'b1;
    startVector(1'b0, 16'd4);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, r2b(pass_vals[i]), 1'b0);
      if (i == 0) begin
        checkOutput("latency_tvalid", 65'(m_tvalid), 65'(1));
        checkOutput("latency_tdata", 65'(m_tdata), {1'b0, r2b(1.0)});
      end
    end
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 5; i++) exp_q.push_back({(i == 3), r2b(pass_vals[i])});
    checkStream("pass", base, vd_base, 1);
    checkOutput("pass_err", 65'(err), 65'(0));

    // Reduce mode, len 3
    base = got_q.size();
    vd_base = vd_cnt;
    startVector(1'b1, 16'd3);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, r2b(red_vals[i]), 1'b0);
    for (int i = 0; i < 3; i++) tick();
    exp_q.push_back({1'b1, r2b(6.0)});
    exp_q.push_back({1'b1, r2b(9.0)});
    checkStream("reduce", base, vd_base, 2);
    checkOutput("reduce_err", 65'(err), 65'(0));

    // Credit, overflow and full push+pop
    base = got_q.size();
    vd_base = vd_cnt;
    m_tready = 1'b0;
    startVector(1'b0, 16'd16);
    checkOutput("credit_initial", 65'(credit_ok), 65'(1));
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("credit_after15", 65'(credit_ok), 65'(1));
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("credit_after16", 65'(credit_ok), 65'(0));
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 64'(i), 1'b0);
    checkOutput("full_tvalid", 65'(m_tvalid), 65'(1));
    checkOutput("full_credit", 65'(credit_ok), 65'(0));
    checkOutput("full_head", {m_tlast, m_tdata}, {1'b0, 64'd1});
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    checkOutput("credit_after_pop", 65'(credit_ok), 65'(1));
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 64'd17, 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b1, 64'd18, 1'b0);
    checkOutput("overflow_err", 65'(err), 65'(2'b01));
    checkOutput("overflow_head", {m_tlast, m_tdata}, {1'b0, 64'd2});
    applyStimulus(1'b0, '0, 1'b1);
    m_tready = 1'b1;
    applyStimulus(1'b1, 64'd19, 1'b0);
    m_tready = 1'b0;
    checkOutput("full_pushpop_credit", 65'(credit_ok), 65'(0));
    checkOutput("full_pushpop_head", {m_tlast, m_tdata}, {1'b0, 64'd3});
    m_tready = 1'b1;
    for (int i = 0; i < 40 && m_tvalid; i++) tick();
    checkOutput("drain_done", 65'(m_tvalid), 65'(0));
    for (int i = 1; i <= 17; i++) exp_q.push_back({(i == 16), 64'(i)});
    exp_q.push_back({1'b0, 64'd19});
    checkStream("credit", base, vd_base, 1);

    // Underflow: result with nothing in flight
    applyStimulus(1'b1, 64'd7, 1'b0);
    checkOutput("underflow_err", 65'(err), 65'(2'b11));
    checkOutput("underflow_inflight", 65'(dut.inflight), 65'(0));
    tick();

    // Mid-stream reset, then len 0 in reduce mode
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 64'(40 + i), 1'b0);
    checkOutput("prereset_tvalid", 65'(m_tvalid), 65'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_tvalid", 65'(m_tvalid), 65'(0));
    checkOutput("midrst_credit", 65'(credit_ok), 65'(1));
    checkOutput("midrst_err", 65'(err), 65'(0));
    checkOutput("midrst_inflight", 65'(dut.inflight), 65'(0));
    base = got_q.size();
    vd_base = vd_cnt;
    m_tready = 1'b1;
    startVector(1'b1, 16'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'(100 + i), 1'b0);
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 64'(100 + i)});
    checkStream("len0", base, vd_base, 3);
    checkOutput("len0_err", 65'(err), 65'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
